// File: rtl/sprite_update_sched.sv
// rtl/sprite_update_sched.sv - frame-atomic sprite register write scheduler
//
// Queues CPU register writes in a FIFO and replays them to the sprite
// register file only during vertical blanking, so a sprite never tears.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   enable            gates new vblank rises (FIFO keeps accepting)
//   flush             discard all queued entries
//   clear_status      clear sticky overflow / late_err
//   vblank            vertical-blank level from the timing generator
//   cpu_wr_*          CPU write request; ready = FIFO not full
//   reg_wr_*          registered write strobe/address/data to sprite regs
//   fifo_count        queued entries
//   commit_done       one-cycle pulse when a frame's batch fully applied
//   overflow          sticky: write dropped on full FIFO
//   late_err          sticky: vblank ended before the batch drained
module sprite_update_sched #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       flush,
    input  logic                       clear_status,
    input  logic                       vblank,
    input  logic                       cpu_wr_valid,
    input  logic [ADDR_W-1:0]          cpu_wr_addr,
    input  logic [DATA_W-1:0]          cpu_wr_data,
    output logic                       cpu_wr_ready,
    output logic                       reg_wr_en,
    output logic [ADDR_W-1:0]          reg_wr_addr,
    output logic [DATA_W-1:0]          reg_wr_data,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       commit_done,
    output logic                       overflow,
    output logic                       late_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    pending_q, pending_d;
    logic                vblank_q;
    logic                reg_wr_en_q, reg_wr_en_d;
    logic [ADDR_W-1:0]   reg_wr_addr_q, reg_wr_addr_d;
    logic [DATA_W-1:0]   reg_wr_data_q, reg_wr_data_d;
    logic                commit_done_q, commit_done_d;
    logic                overflow_q, overflow_d;
    logic                late_err_q, late_err_d;

    logic [ADDR_W-1:0]   mem_addr_q [DEPTH];
    logic [DATA_W-1:0]   mem_data_q [DEPTH];

    logic push;
    logic pop;
    logic drop;
    logic rise;

    assign cpu_wr_ready = (count_q != CNT_W'(DEPTH));
    // flush beats a same-cycle push: the entry vanishes without counting as a drop
    assign push = cpu_wr_valid && cpu_wr_ready && !flush;
    assign drop = cpu_wr_valid && !cpu_wr_ready && !flush;
    assign rise = vblank && !vblank_q;
    assign pop  = (state_q == COMMIT) && (pending_q != '0) && vblank && !flush;

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        commit_done_d = 1'b0;
        late_err_d    = late_err_q;
        overflow_d    = overflow_q;
        reg_wr_en_d   = pop;
        reg_wr_addr_d = reg_wr_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (clear_status) begin
            overflow_d = 1'b0;
            late_err_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // Snapshot excludes this cycle's push, so it waits a frame
                if (rise && enable) begin
                    state_d   = COMMIT;
                    pending_d = count_q;
                end
            end
            COMMIT: begin
                if (pending_q == '0) begin
                    state_d       = IDLE;
                    commit_done_d = 1'b1;
                end else if (!vblank) begin
                    state_d    = IDLE;
                    pending_d  = '0;
                    late_err_d = 1'b1;
                end else begin
                    pending_d = pending_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            reg_wr_addr_d = mem_addr_q[rd_ptr_q];
            reg_wr_data_d = mem_data_q[rd_ptr_q];
            rd_ptr_d      = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (flush) begin
            state_d       = IDLE;
            pending_d     = '0;
            commit_done_d = 1'b0;
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            pending_q     <= '0;
            vblank_q      <= 1'b0;
            reg_wr_en_q   <= 1'b0;
            reg_wr_addr_q <= '0;
            reg_wr_data_q <= '0;
            commit_done_q <= 1'b0;
            overflow_q    <= 1'b0;
            late_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            pending_q     <= pending_d;
            vblank_q      <= vblank;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            commit_done_q <= commit_done_d;
            overflow_q    <= overflow_d;
            late_err_q    <= late_err_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_addr_q[wr_ptr_q] <= cpu_wr_addr;
            mem_data_q[wr_ptr_q] <= cpu_wr_data;
        end
    end

    assign reg_wr_en   = reg_wr_en_q;
    assign reg_wr_addr = reg_wr_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign fifo_count  = count_q;
    assign commit_done = commit_done_q;
    assign overflow    = overflow_q;
    assign late_err    = late_err_q;
endmodule

// File: tb/tb_sprite_update_sched.sv
// tb/tb_sprite_update_sched.sv - directed self-checking bench for sprite_update_sched
module tb_sprite_update_sched;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              flush;
    logic              clear_status;
    logic              vblank;
    logic              cpu_wr_valid;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              cpu_wr_ready;
    logic              reg_wr_en;
    logic [ADDR_W-1:0] reg_wr_addr;
    logic [DATA_W-1:0] reg_wr_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              commit_done;
    logic              overflow;
    logic              late_err;

    int errors = 0;
    int checks = 0;

    sprite_update_sched #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .clear_status(clear_status), .vblank(vblank),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_addr(cpu_wr_addr),
        .cpu_wr_data(cpu_wr_data), .cpu_wr_ready(cpu_wr_ready),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .fifo_count(fifo_count),
        .commit_done(commit_done), .overflow(overflow), .late_err(late_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cpu_wr_valid = 1'b1;
        cpu_wr_addr  = a;
        cpu_wr_data  = d;
        step();
        cpu_wr_valid = 1'b0;
    endtask

    task automatic check_write(input string name, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d);
        checks++;
        if (reg_wr_en !== 1'b1 || reg_wr_addr !== a || reg_wr_data !== d) begin
            errors++;
            $display("FAIL %s: got en=%b addr=%h data=%h, want en=1 addr=%h data=%h",
                     name, reg_wr_en, reg_wr_addr, reg_wr_data, a, d);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; flush = 1'b0; clear_status = 1'b0;
        vblank = 1'b0; cpu_wr_valid = 1'b0; cpu_wr_addr = '0; cpu_wr_data = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({reg_wr_en, reg_wr_addr, reg_wr_data, commit_done, overflow, late_err,
             cpu_wr_ready, fifo_count} !== {1'b0, 6'h0, 16'h0, 4'b0001, 4'd0}) begin
            errors++;
            $display("FAIL reset: en=%b addr=%h data=%h cd=%b ov=%b late=%b rdy=%b cnt=%0d, want zeros with rdy=1",
                     reg_wr_en, reg_wr_addr, reg_wr_data, commit_done, overflow, late_err,
                     cpu_wr_ready, fifo_count);
        end
    endtask

    task automatic test_basic();
        push(6'h04, 16'h1020);
        push(6'h06, 16'hAAAA);
        push(6'h08, 16'h5555);
        checks++;
        if (fifo_count !== 4'd3) begin
            errors++; $display("FAIL basic_count: got %0d want 3", fifo_count);
        end
        vblank = 1'b1;                 // cycle E
        step();                        // E+1
        checks++;
        if (reg_wr_en !== 1'b0) begin
            errors++; $display("FAIL basic_early: got en=%b want 0", reg_wr_en);
        end
        step(); check_write("basic_w0", 6'h04, 16'h1020);
        step(); check_write("basic_w1", 6'h06, 16'hAAAA);
        step(); check_write("basic_w2", 6'h08, 16'h5555);
        step();                        // E+5
        checks++;
        if (commit_done !== 1'b1 || reg_wr_en !== 1'b0 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL basic_done: got cd=%b en=%b cnt=%0d want cd=1 en=0 cnt=0",
                     commit_done, reg_wr_en, fifo_count);
        end
        step();
        checks++;
        if (commit_done !== 1'b0) begin
            errors++; $display("FAIL basic_pulse: got cd=%b want 0", commit_done);
        end
        vblank = 1'b0;
        step();
    endtask

    task automatic test_snapshot();
        push(6'h10, 16'h0001);
        push(6'h12, 16'h0002);
        vblank = 1'b1;                 // E, with a push in the same cycle
        push(6'h14, 16'h0003);         // now E+1
        step(); check_write("snap_w0", 6'h10, 16'h0001);
        step(); check_write("snap_w1", 6'h12, 16'h0002);
        step();                        // E+4
        checks++;
        if (commit_done !== 1'b1 || reg_wr_en !== 1'b0 || fifo_count !== 4'd1) begin
            errors++;
            $display("FAIL snap_done: got cd=%b en=%b cnt=%0d want cd=1 en=0 cnt=1",
                     commit_done, reg_wr_en, fifo_count);
        end
        vblank = 1'b0;
        step();
        vblank = 1'b1;
        step();
        step(); check_write("snap_next", 6'h14, 16'h0003);
        step();
        checks++;
        if (commit_done !== 1'b1 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL snap_next_done: got cd=%b cnt=%0d want cd=1 cnt=0", commit_done, fifo_count);
        end
        vblank = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) push(6'(i), 16'(i));
        checks++;
        if (cpu_wr_ready !== 1'b0 || fifo_count !== 4'd8 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full: got rdy=%b cnt=%0d ov=%b want rdy=0 cnt=8 ov=0",
                     cpu_wr_ready, fifo_count, overflow);
        end
        push(6'h3F, 16'hDEAD);
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 4'd8) begin
            errors++;
            $display("FAIL ovf_drop: got ov=%b cnt=%0d want ov=1 cnt=8", overflow, fifo_count);
        end
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got ov=%b want 0", overflow);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (fifo_count !== 4'd0 || cpu_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flush: got cnt=%0d rdy=%b want cnt=0 rdy=1", fifo_count, cpu_wr_ready);
        end
    endtask

    task automatic test_late();
        for (int i = 0; i < DEPTH; i++) push(6'(8'h20 + i), 16'(16'h100 + i));
        vblank = 1'b1;                 // E
        step();                        // E+1
        step(); check_write("late_w0", 6'h20, 16'h0100);
        step(); check_write("late_w1", 6'h21, 16'h0101);
        step(); check_write("late_w2", 6'h22, 16'h0102);   // E+4
        vblank = 1'b0;
        step();                        // E+5
        checks++;
        if (reg_wr_en !== 1'b0 || late_err !== 1'b1 || commit_done !== 1'b0 || fifo_count !== 4'd5) begin
            errors++;
            $display("FAIL late_abort: got en=%b late=%b cd=%b cnt=%0d want en=0 late=1 cd=0 cnt=5",
                     reg_wr_en, late_err, commit_done, fifo_count);
        end
        step();
        vblank = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check_write("late_rest", 6'(8'h23 + i), 16'(16'h103 + i));
        end
        step();
        checks++;
        if (commit_done !== 1'b1 || fifo_count !== 4'd0 || late_err !== 1'b1) begin
            errors++;
            $display("FAIL late_done: got cd=%b cnt=%0d late=%b want cd=1 cnt=0 late=1",
                     commit_done, fifo_count, late_err);
        end
        vblank = 1'b0;
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        checks++;
        if (late_err !== 1'b0) begin
            errors++; $display("FAIL late_clear: got late=%b want 0", late_err);
        end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 6; i++) push(6'(8'h30 + i), 16'(16'h300 + i));
        vblank = 1'b1;                 // E
        step();
        step(); check_write("flush_w0", 6'h30, 16'h0300);
        step(); check_write("flush_w1", 6'h31, 16'h0301);   // E+3
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (reg_wr_en !== 1'b0 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL flush_stop: got en=%b cnt=%0d want en=0 cnt=0", reg_wr_en, fifo_count);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (commit_done !== 1'b0 || reg_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL flush_quiet: got cd=%b en=%b want 0 0", commit_done, reg_wr_en);
            end
        end
        vblank = 1'b0;
        step();

        for (int i = 0; i < 6; i++) push(6'(8'h30 + i), 16'(16'h300 + i));
        vblank = 1'b1;
        step();
        step(); check_write("rst_w0", 6'h30, 16'h0300);
        step(); check_write("rst_w1", 6'h31, 16'h0301);
        rst_n = 1'b0;
        vblank = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if ({reg_wr_en, reg_wr_addr, reg_wr_data, commit_done, overflow, late_err,
             cpu_wr_ready, fifo_count} !== {1'b0, 6'h0, 16'h0, 4'b0001, 4'd0}) begin
            errors++;
            $display("FAIL rst_mid: en=%b addr=%h data=%h cd=%b ov=%b late=%b rdy=%b cnt=%0d, want reset values",
                     reg_wr_en, reg_wr_addr, reg_wr_data, commit_done, overflow, late_err,
                     cpu_wr_ready, fifo_count);
        end
        step();
    endtask

    task automatic test_enable();
        push(6'h3A, 16'hBEEF);
        push(6'h3B, 16'hCAFE);
        enable = 1'b0;
        vblank = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (reg_wr_en !== 1'b0 || commit_done !== 1'b0 || fifo_count !== 4'd2) begin
                errors++;
                $display("FAIL enable_gate: got en=%b cd=%b cnt=%0d want 0 0 2",
                         reg_wr_en, commit_done, fifo_count);
            end
        end
        enable = 1'b1;
        vblank = 1'b0;
        step();
        vblank = 1'b1;
        step();
        step(); check_write("enable_w0", 6'h3A, 16'hBEEF);
        step(); check_write("enable_w1", 6'h3B, 16'hCAFE);
        vblank = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_snapshot();
        test_overflow();
        test_late();
        test_flush_reset();
        test_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sprite_update_sched.md
# sprite_update_sched

Frame-atomic write scheduler between the TinyQV register interface and the sprite engine's position, control and bitmap registers. CPU writes are queued in a FIFO and applied only during vertical blanking, so a sprite never tears mid-frame. It also raises a commit-done event per frame and keeps sticky error flags for drops and for missed vblank deadlines. It sits between the bus decode and the sprite register file; the engine's timing generator supplies `vblank`.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `ADDR_W`, 6, register address width
- `DATA_W`, 16, register write data width
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `enable`  in  1  scheduler enable; 0 = edges ignored, FIFO still accepts
- `flush`  in  1  discard all queued entries (pulse)
- `clear_status`  in  1  clear sticky flags (pulse)
- `vblank`  in  1  vertical-blank level from timing generator
- `cpu_wr_valid`  in  1  CPU write request
- `cpu_wr_addr`  in  ADDR_W  target register address
- `cpu_wr_data`  in  DATA_W  write data
- `cpu_wr_ready`  out  1  FIFO not full (combinational)
- `reg_wr_en`  out  1  write strobe to sprite register file (registered)
- `reg_wr_addr`  out  ADDR_W  registered address
- `reg_wr_data`  out  DATA_W  registered data
- `fifo_count`  out  $clog2(DEPTH+1)  queued entries
- `commit_done`  out  1  one-cycle pulse when a frame's batch fully applied
- `overflow`  out  1  sticky: write dropped on full FIFO
- `late_err`  out  1  sticky: vblank ended before batch drained

## Operation
- FIFO: push when `cpu_wr_valid && cpu_wr_ready`; `cpu_wr_valid` while full drops the entry and sets `overflow`. Simultaneous push and pop permitted when full (ready stays 0; the pop frees space for the next cycle).
- `vblank_q` register holds the previous-cycle `vblank`. Rise = `vblank && !vblank_q`.
- States: IDLE, COMMIT.
- IDLE: on rise with `enable=1` go to COMMIT, with `pending <= fifo_count` taken before this cycle's push. Entries pushed on or after the rise cycle wait for the next frame.
- COMMIT, `pending>0`, `vblank=1`: pop the head, drive it on the `reg_wr_*` outputs next cycle, `pending--`.
- COMMIT, `pending>0`, `vblank=0`: no pop; set `late_err`; go to IDLE. Remaining entries stay queued for the next vblank. No `commit_done`.
- COMMIT, `pending==0`: go to IDLE; `commit_done<=1`. An empty snapshot still pulses `commit_done`.
- `enable` deasserted in COMMIT: finish the current batch. `enable` gates only new rises.
- `flush`: `fifo_count<=0`, `pending<=0`, state IDLE, no `commit_done`. It beats a same-cycle push; that entry is discarded, not counted as overflow.
- `clear_status` clears `overflow` and `late_err`. A same-cycle set event wins.
- Reset: FIFO empty, state IDLE, `vblank_q=0`, `reg_wr_en=0`, `reg_wr_addr=0`, `reg_wr_data=0`, `commit_done=0`, `overflow=0`, `late_err=0`, `cpu_wr_ready=1`. Reset mid-COMMIT abandons the batch silently.
- Order is preserved strictly FIFO. Duplicate addresses are applied in arrival order; the last value wins.

## Timing
- Cycle E = first cycle `vblank=1` is sampled with `vblank_q=0`.
- E+1: first pop. `reg_wr_en` is high E+2 … E+N+1 for N snapshotted entries, one entry per cycle, no bubbles.
- `commit_done` is high at E+N+2 for exactly 1 cycle. For N=0 it is high at E+2.
- `fifo_count` updates the cycle after a push/pop. `cpu_wr_ready` follows `fifo_count` combinationally.
- Throughput is 1 write per cycle, so any batch ≤ DEPTH drains well inside a 38-line vblank.

## Test plan
- Basic batch: push 3 writes (0x04←0x1020, 0x06←0xAAAA, 0x08←0x5555) while `vblank=0`, then raise `vblank` at E. Expect no `reg_wr_en` before E+2. Writes appear in order at E+2..E+4; `commit_done` pulses at E+5; `fifo_count=0`.
- Snapshot boundary: queue 2 entries, then push a third on cycle E. Expect only 2 writes this frame and `fifo_count=1` after. The third is written at the next vblank rise.
- Overflow: push DEPTH+1 entries with no vblank. Expect `cpu_wr_ready=0` after the 8th, the 9th dropped, `overflow=1`. `clear_status` returns it to 0.
- Late: queue 8 entries; hold `vblank` high for 4 cycles only, starting at E. Expect 3 writes, `late_err=1`, no `commit_done`, `fifo_count=5`. The next vblank drains the remaining 5 and pulses `commit_done`.
- Flush/reset: start a 6-entry batch, assert `flush` at E+3. Expect writes only at E+2..E+3, then `fifo_count=0` and no `commit_done`. Repeat with `rst_n=0` instead: all outputs take reset values the next cycle.
- Enable gating: with `enable=0` and `vblank` rising, expect no writes, with `commit_done` held low and `fifo_count` unchanged.
